// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP/halt encodings and FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls and imem data in, PC and IF/ID contents out.
interface fetch_stage_if;
  logic        Stall;
  logic        BranchTaken_D;
  logic [31:0] BranchTarget_D;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PCPlus4_D;
  logic        Valid_D;
  logic        Done;

  // Fetch stage side: owns PC and the IF/ID register.
  modport master (
    input  Stall, BranchTaken_D, BranchTarget_D, Instr_F,
    output PC_F, Instr_D, PCPlus4_D, Valid_D, Done
  );

  // Environment side: hazard unit, decode branch logic, instruction memory.
  modport slave (
    output Stall, BranchTaken_D, BranchTarget_D, Instr_F,
    input  PC_F, Instr_D, PCPlus4_D, Valid_D, Done
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load on enable, synchronous flush to a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pcplus4_q;
  logic        valid_q;

  // Flush wins over load; with neither, the register holds (stall).
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      instr_q   <= NOP_WORD;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else if (en_i) begin
      instr_q   <= instr_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, run/drain/done FSM, halt detection and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4;
  logic [3:0]   cnt_q;
  logic         done_q;

  logic         ifid_en;
  logic         ifid_flush;
  logic [31:0]  instr_d_q;
  logic [31:0]  pcplus4_d_q;
  logic         valid_d_q;
  logic         halt_seen;

  assign pc_plus4  = pc_q + 32'd4;
  assign halt_seen = valid_d_q && (instr_d_q == HALT_WORD);

  // IF/ID control: stall holds, branch/halt inject a bubble, DRAIN/DONE keep it a bubble.
  always_comb begin
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    if (state_q == RUN) begin
      if (!bus.Stall) begin
        if (bus.BranchTaken_D || halt_seen) ifid_flush = 1'b1;
        else                                ifid_en    = 1'b1;
      end
    end else begin
      ifid_flush = 1'b1;
    end
  end

  // FSM, PC and drain counter. Done is registered and sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.Stall) begin
            if (bus.BranchTaken_D) begin
              pc_q <= bus.BranchTarget_D;
            end else if (halt_seen) begin
              state_q <= DRAIN;
              cnt_q   <= 4'd0;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        DRAIN: begin
          // Stall/branch ignored: decode only holds bubbles now.
          if (cnt_q == DRAIN_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .reset     (reset),
    .en_i      (ifid_en),
    .flush_i   (ifid_flush),
    .instr_i   (bus.Instr_F),
    .pcplus4_i (pc_plus4),
    .instr_o   (instr_d_q),
    .pcplus4_o (pcplus4_d_q),
    .valid_o   (valid_d_q)
  );

  assign bus.PC_F      = pc_q;
  assign bus.Instr_D   = instr_d_q;
  assign bus.PCPlus4_D = pcplus4_d_q;
  assign bus.Valid_D   = valid_d_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vectors for fetch_stage; expectations queued per cycle, checked by a monitor.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] halt_addr;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .HALT_WORD    (32'hFFFF_FFFF),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word at A is 0x1000_0000 + A, halt word at halt_addr.
  assign bus.Instr_F = (bus.PC_F == halt_addr) ? 32'hFFFF_FFFF : (32'h1000_0000 + bus.PC_F);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        done;
    logic [15:0] id;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic vec(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4,
                     input logic v, input logic d);
    exp_t e;
    @(negedge clk);
    reset              = r;
    bus.Stall          = s;
    bus.BranchTaken_D  = b;
    bus.BranchTarget_D = t;
    e.pc = pc; e.instr = ins; e.pc4 = p4; e.valid = v; e.done = d; e.id = 16'(vec_id);
    expq.push_back(e);
    vec_id++;
  endtask

  // Monitor: after each active edge, compare DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (bus.PC_F !== e.pc) begin
          errors++;
          $display("FAIL vec%0d PC_F got %h want %h", e.id, bus.PC_F, e.pc);
        end
        checks++;
        if (bus.Instr_D !== e.instr) begin
          errors++;
          $display("FAIL vec%0d Instr_D got %h want %h", e.id, bus.Instr_D, e.instr);
        end
        checks++;
        if (bus.PCPlus4_D !== e.pc4) begin
          errors++;
          $display("FAIL vec%0d PCPlus4_D got %h want %h", e.id, bus.PCPlus4_D, e.pc4);
        end
        checks++;
        if (bus.Valid_D !== e.valid) begin
          errors++;
          $display("FAIL vec%0d Valid_D got %b want %b", e.id, bus.Valid_D, e.valid);
        end
        checks++;
        if (bus.Done !== e.done) begin
          errors++;
          $display("FAIL vec%0d Done got %b want %b", e.id, bus.Done, e.done);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.Stall = 1'b0;
    bus.BranchTaken_D = 1'b0;
    bus.BranchTarget_D = 32'h0;
    halt_addr = 32'h84;

    //  rst stl br  target          PC_F           Instr_D        PCPlus4_D      V  Done
    vec(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
    // sequential fetch
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h1000_0004, 32'h0000_0008, 1, 0);
    // stall two cycles at PC 8
    vec(0, 1, 0, 32'h0,          32'h0000_0008, 32'h1000_0004, 32'h0000_0008, 1, 0);
    vec(0, 1, 0, 32'h0,          32'h0000_0008, 32'h1000_0004, 32'h0000_0008, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_000C, 32'h1000_0008, 32'h0000_000C, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0010, 32'h1000_000C, 32'h0000_0010, 1, 0);
    // taken branch at 0x10 to 0x40: one bubble
    vec(0, 0, 1, 32'h40,         32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0044, 32'h1000_0040, 32'h0000_0044, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0048, 32'h1000_0044, 32'h0000_0048, 1, 0);
    // stall + branch together: stall wins, then branch taken
    vec(0, 1, 1, 32'h80,         32'h0000_0048, 32'h1000_0044, 32'h0000_0048, 1, 0);
    vec(0, 0, 1, 32'h80,         32'h0000_0080, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0084, 32'h1000_0080, 32'h0000_0084, 1, 0);
    // halt word fetched from 0x84
    vec(0, 0, 0, 32'h0,          32'h0000_0088, 32'hFFFF_FFFF, 32'h0000_0088, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 0); // enter DRAIN
    vec(0, 1, 0, 32'h0,          32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 1, 32'h200,        32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 1); // 4 after entry
    vec(0, 0, 1, 32'h300,        32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 1);
    vec(0, 1, 0, 32'h0,          32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 0, 1);

    // second run: halt at 0x4, reset while counter at 2
    halt_addr = 32'h4;
    vec(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0008, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 0, 0); // cnt 0
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 0, 0); // cnt 1
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 0, 0); // cnt 2
    vec(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
    @(negedge clk);
    halt_addr = 32'h8000_0000;
    // fetch resumes normally
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h1000_0004, 32'h0000_0008, 1, 0);
    // unaligned target passes through untouched
    vec(0, 0, 1, 32'h101,        32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0105, 32'h1000_0101, 32'h0000_0105, 1, 0);
    // PC+4 wraps at the top of the address space
    vec(0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 0);
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline. Owns the program counter, drives the instruction-memory address, and registers the fetched word into the decode stage. Directly consumes `Stall` from the decode-stage hazard detector, along with the branch decision resolved in decode. Also detects the halt word, drains the pipeline and raises `Done`.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that ends the program.
- `DRAIN_CYCLES`, default 4: cycles after halt enters decode before `Done` rises; range 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `Stall`  in  1: from the hazard detector; freezes PC and IF/ID.
- `BranchTaken_D`  in  1: branch in decode resolved taken.
- `BranchTarget_D`  in  32: redirect address, valid when `BranchTaken_D` is 1.
- `Instr_F`  in  32: instruction-memory read data for `PC_F`, combinational same cycle.
- `PC_F`  out  32: instruction-memory address (current PC).
- `Instr_D`  out  32: registered instruction to decode.
- `PCPlus4_D`  out  32: registered `PC_F+4` of that instruction.
- `Valid_D`  out  1: `Instr_D` is a real instruction, not a bubble.
- `Done`  out  1: program has halted and the pipeline has drained; sticky.

## Operation

- FSM states are RUN, DRAIN and DONE. Reset enters RUN.
- RUN state: per-cycle priority is reset, then Stall, then branch, then halt, then normal.
  - `Stall=1`: PC, `Instr_D`, `PCPlus4_D` and `Valid_D` all hold. A `BranchTaken_D` or halt seen in the same cycle is ignored; it is re-evaluated when the stall clears.
  - `BranchTaken_D=1`, no stall: PC is loaded with `BranchTarget_D`. IF/ID is flushed: `Instr_D`=0 (NOP), `Valid_D`=0, `PCPlus4_D`=0.
  - Halt condition, no stall, no branch: `Valid_D=1` and `Instr_D==HALT_WORD`. The FSM moves to DRAIN. PC holds. IF/ID is loaded with a bubble, and the drain counter is cleared.
  - Normal case: PC is loaded with PC+4. IF/ID captures `Instr_F`, `PC_F+4` and `Valid_D=1`.
- DRAIN state:
  - PC is frozen and IF/ID is held as a bubble.
  - `Stall` and `BranchTaken_D` are ignored, because decode contains only bubbles.
  - The counter increments each cycle. When the counter reaches `DRAIN_CYCLES-1`, the FSM moves to DONE.
- DONE state: `Done=1`. PC is frozen and IF/ID holds a bubble. The block stays in DONE until reset.
- Arithmetic: PC+4 is 32-bit modular and wraps from 32'hFFFF_FFFC to 0 with no flag. Bits [1:0] of `BranchTarget_D` are passed through unchanged; no alignment check is performed.
- Reset mid-operation, in any state, forces every register to its reset value on the next edge.

## Timing

- Reset values: `PC_F`=`RESET_PC`, `Instr_D`=0, `PCPlus4_D`=0, `Valid_D`=0, `Done`=0, state=RUN, counter=0.
- Fetch latency: the instruction at address A appears on `Instr_D` one cycle after `PC_F`=A, provided there is no stall.
- Taken branch: one bubble. The target is presented on `PC_F` in the cycle after `BranchTaken_D`, and its instruction reaches `Instr_D` one cycle later.
- Stall: zero-latency freeze. Outputs in cycle N+1 equal those in cycle N when `Stall=1` in cycle N.
- Halt: `Done` rises exactly `DRAIN_CYCLES` cycles after the edge at which the FSM entered DRAIN.
- All outputs are registered, except that `PC_F` is the PC register itself.

## Structure

- Shared pipeline package holds:
  - the `NOP_WORD` (32'h0) constant;
  - the `HALT_WORD` default;
  - the `fetch_state_t` enum {RUN, DRAIN, DONE}.
- One sub-module is natural: `if_id_reg`. It contains the IF/ID register with enable (`~Stall`) and synchronous flush. The PC register, FSM and drain counter stay in `fetch_stage`.

## Test plan

- Reset release with `Instr_F` following a memory model of sequential words: `PC_F` goes 0, 4, 8 and `Instr_D` lags by one cycle with `Valid_D=1`.
- `Stall=1` for 2 cycles at `PC_F`=8: `PC_F` stays 8 and `Instr_D` and `PCPlus4_D`=8 are held. After release, `PC_F`=12 next cycle.
- `BranchTaken_D=1` with `BranchTarget_D`=0x40 at `PC_F`=0x10: next `PC_F`=0x40 with `Valid_D=0`, then the instruction at 0x40 appears on `Instr_D` with `PCPlus4_D`=0x44.
- `Stall=1` and `BranchTaken_D=1` in the same cycle: PC holds (no redirect). The next cycle, with `Stall=0` and `BranchTaken_D=1`, takes the redirect.
- `HALT_WORD` fetched with `DRAIN_CYCLES`=4: the FSM enters DRAIN, `PC_F` freezes, `Valid_D=0`, and `Done=1` exactly 4 cycles later and stays high. A later `BranchTaken_D=1` has no effect.
- `reset` asserted during DRAIN with the counter at 2: next cycle `PC_F`=0, `Done=0`, state RUN, and fetch resumes normally.
